id_ex_stage: RTL

- ID/EX pipeline register for the 5-stage RV32 core. It sits between the decode stage (Control, register file, immediate generator) and the EX stage (ALU control, forwarding unit, ALU).
- It also contains the load-use hazard detector. Stall_o feeds Control's Stall_i, PC write enable and IF/ID write enable.
- It inserts bubbles on load-use, flushes on taken branch, freezes on a global memory hold, and counts inserted bubbles.

---
 rtl/core_pkg.sv | 43 ++++
 rtl/hazard_detect.sv | 33 +++
 rtl/id_ex_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the 5-stage RV32 core pipeline registers.
//   - CTRL_W and bit positions of each field in the 8-bit control bundle
//     {Branch, MemtoReg, ALUOp[1:0], MemWrite, MemRead, ALUSrc, RegWrite}
//   - ALUOp encodings
//   - default data / register-index widths
//   - ctrl_t packed struct, laid out in the same bit order as the bundle
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int CTRL_W         = 8;
  localparam int FUNCT_W        = 10;
  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  // Bit positions inside the control bundle
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_ALUOP_LO = 4;
  localparam int CTRL_ALUOP_HI = 5;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_BRANCH   = 7;

  // ALUOp encodings
  localparam logic [1:0] ALUOP_ADD    = 2'b00;  // loads/stores, address add
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;  // decode from funct fields

  // MSB-first member order matches the bundle bit order above.
  typedef struct packed {
    logic       branch;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Load-use hazard detector, purely combinational.
// A stall is needed when the instruction in EX is a real load writing a
// non-zero register that the instruction in ID reads as rs1 or rs2.
// Ports:
//   ex_valid_i     in   1           EX holds a real instruction
//   ex_mem_read_i  in   1           EX instruction is a load
//   ex_rd_i        in   REG_ADDR_W  EX destination register
//   id_rs1_i       in   REG_ADDR_W  ID source register 1
//   id_rs2_i       in   REG_ADDR_W  ID source register 2
//   stall_o        out  1           load-use hazard present
// -----------------------------------------------------------------------------
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  output logic                  stall_o
);

  logic rd_nonzero;
  logic rd_match;

  // x0 is hard-wired to zero, so a load into x0 never produces a dependency.
  assign rd_nonzero = (ex_rd_i != '0);
  assign rd_match   = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);
  assign stall_o    = ex_valid_i & ex_mem_read_i & rd_nonzero & rd_match;

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection and a saturating
// bubble counter.
// Edge update priority: Hold (freeze everything) > Flush > load-use Stall >
// capture of the ID inputs. Flush and Stall both load a bubble (all fields
// zero, EX_Valid_o=0) and bump the counter once.
// EX_Valid_o semantics: 1 means the EX fields describe a real instruction;
// 0 means a bubble, and consumers must ignore every EX_* field.
// Ports:
//   clk_i, rst_i                 clock (rising), async active-low reset
//   Hold_i                       global freeze (data-cache miss)
//   Flush_i                      taken-branch flush
//   ID_*                         decode-stage control, data and reg fields
//   EX_*                         registered copies for the EX stage
//   EX_Valid_o                   real instruction (1) or bubble (0)
//   Stall_o                      load-use hazard, combinational
//   PCWrite_o, IFIDWrite_o       ~Stall_o
//   BubbleCnt_o                  saturating inserted-bubble count
// -----------------------------------------------------------------------------
module id_ex_stage
  import core_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  Hold_i,
  input  logic                  Flush_i,
  input  logic [7:0]            ID_Ctrl_i,
  input  logic [DATA_W-1:0]     ID_RS1data_i,
  input  logic [DATA_W-1:0]     ID_RS2data_i,
  input  logic [DATA_W-1:0]     ID_Imm_i,
  input  logic [DATA_W-1:0]     ID_PC_i,
  input  logic [9:0]            ID_Funct_i,
  input  logic [REG_ADDR_W-1:0] ID_RS1addr_i,
  input  logic [REG_ADDR_W-1:0] ID_RS2addr_i,
  input  logic [REG_ADDR_W-1:0] ID_RDaddr_i,
  output logic [7:0]            EX_Ctrl_o,
  output logic [DATA_W-1:0]     EX_RS1data_o,
  output logic [DATA_W-1:0]     EX_RS2data_o,
  output logic [DATA_W-1:0]     EX_Imm_o,
  output logic [DATA_W-1:0]     EX_PC_o,
  output logic [9:0]            EX_Funct_o,
  output logic [REG_ADDR_W-1:0] EX_RS1addr_o,
  output logic [REG_ADDR_W-1:0] EX_RS2addr_o,
  output logic [REG_ADDR_W-1:0] EX_RDaddr_o,
  output logic                  EX_Valid_o,
  output logic                  Stall_o,
  output logic                  PCWrite_o,
  output logic                  IFIDWrite_o,
  output logic [CNT_W-1:0]      BubbleCnt_o
);

  ctrl_t                 ctrl_q,   ctrl_d;
  logic [DATA_W-1:0]     rs1data_q, rs1data_d;
  logic [DATA_W-1:0]     rs2data_q, rs2data_d;
  logic [DATA_W-1:0]     imm_q,    imm_d;
  logic [DATA_W-1:0]     pc_q,     pc_d;
  logic [9:0]            funct_q,  funct_d;
  logic [REG_ADDR_W-1:0] rs1addr_q, rs1addr_d;
  logic [REG_ADDR_W-1:0] rs2addr_q, rs2addr_d;
  logic [REG_ADDR_W-1:0] rdaddr_q, rdaddr_d;
  logic                  valid_q,  valid_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;

  logic stall;
  logic bubble;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rd_i       (rdaddr_q),
    .id_rs1_i      (ID_RS1addr_i),
    .id_rs2_i      (ID_RS2addr_i),
    .stall_o       (stall)
  );

  // Flush and stall on the same edge collapse into one bubble.
  assign bubble = Flush_i | stall;

  always_comb begin
    ctrl_d    = ctrl_q;
    rs1data_d = rs1data_q;
    rs2data_d = rs2data_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    funct_d   = funct_q;
    rs1addr_d = rs1addr_q;
    rs2addr_d = rs2addr_q;
    rdaddr_d  = rdaddr_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;

    if (Hold_i) begin
      // Freeze: defaults already hold every register.
    end else if (bubble) begin
      // Control is zeroed here so a bubble can never write state even if
      // Control itself did not gate its outputs on the stall.
      ctrl_d    = '0;
      rs1data_d = '0;
      rs2data_d = '0;
      imm_d     = '0;
      pc_d      = '0;
      funct_d   = '0;
      rs1addr_d = '0;
      rs2addr_d = '0;
      rdaddr_d  = '0;
      valid_d   = 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      ctrl_d    = ctrl_t'(ID_Ctrl_i);
      rs1data_d = ID_RS1data_i;
      rs2data_d = ID_RS2data_i;
      imm_d     = ID_Imm_i;
      pc_d      = ID_PC_i;
      funct_d   = ID_Funct_i;
      rs1addr_d = ID_RS1addr_i;
      rs2addr_d = ID_RS2addr_i;
      rdaddr_d  = ID_RDaddr_i;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q    <= '0;
      rs1data_q <= '0;
      rs2data_q <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      funct_q   <= '0;
      rs1addr_q <= '0;
      rs2addr_q <= '0;
      rdaddr_q  <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs1data_q <= rs1data_d;
      rs2data_q <= rs2data_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      funct_q   <= funct_d;
      rs1addr_q <= rs1addr_d;
      rs2addr_q <= rs2addr_d;
      rdaddr_q  <= rdaddr_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign EX_Ctrl_o    = ctrl_q;
  assign EX_RS1data_o = rs1data_q;
  assign EX_RS2data_o = rs2data_q;
  assign EX_Imm_o     = imm_q;
  assign EX_PC_o      = pc_q;
  assign EX_Funct_o   = funct_q;
  assign EX_RS1addr_o = rs1addr_q;
  assign EX_RS2addr_o = rs2addr_q;
  assign EX_RDaddr_o  = rdaddr_q;
  assign EX_Valid_o   = valid_q;
  assign Stall_o      = stall;
  assign PCWrite_o    = ~stall;
  assign IFIDWrite_o  = ~stall;
  assign BubbleCnt_o  = cnt_q;

endmodule
